// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sizing helpers, state encoding and element slicing for the systolic feeder
package systolic_pkg;
   typedef enum logic [1:0] {IDLE, FEED, HOLD} state_t;
   function automatic int max_dim(int bus_w, int data_w);
      return bus_w / data_w;
   endfunction
   function automatic int feed_cycles(int md);
      return 3 * md - 2;
   endfunction
   function automatic int cnt_w(int md);
      return (feed_cycles(md) > 1) ? $clog2(feed_cycles(md)) : 1;
   endfunction
   function automatic int addr_w(int md);
      return (md > 1) ? $clog2(md) : 1;
   endfunction
   function automatic int elem_lsb(int k, int data_w);
      return k * data_w;
   endfunction
   localparam int MAX_DIM     = max_dim(64, 32);
   localparam int CNT_W       = cnt_w(MAX_DIM);
   localparam int FEED_CYCLES = feed_cycles(MAX_DIM);
endpackage

// File: rtl/feeder_operand_bank.sv
// feeder_operand_bank: A-row and B-column buffers with skewed per-slot combinational read
module feeder_operand_bank
   import systolic_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int BUS_WIDTH  = 64,
   localparam int MD         = max_dim(BUS_WIDTH, DATA_WIDTH),
   localparam int AW         = addr_w(MD),
   localparam int CW         = cnt_w(MD)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     we_i,
   input  logic                     sel_i,
   input  logic [AW-1:0]            addr_i,
   input  logic [BUS_WIDTH-1:0]     data_i,
   input  logic [CW-1:0]            idx_i,
   output logic [MD*DATA_WIDTH-1:0] left_o,
   output logic [MD*DATA_WIDTH-1:0] up_o
);
   logic [BUS_WIDTH-1:0] a_q [MD];
   logic [BUS_WIDTH-1:0] b_q [MD];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q <= '{default: '0};
         b_q <= '{default: '0};
      end else if (we_i) begin
         if (sel_i) b_q[addr_i] <= data_i;
         else       a_q[addr_i] <= data_i;
      end
   end

   // slot k carries element idx-k of its word; anything outside the word is zero padding
   always_comb begin
      left_o = '0;
      up_o   = '0;
      for (int k = 0; k < MD; k++) begin
         if (int'(idx_i) >= k && int'(idx_i) - k < MD) begin
            left_o[elem_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = a_q[k][elem_lsb(int'(idx_i) - k, DATA_WIDTH) +: DATA_WIDTH];
            up_o[elem_lsb(k, DATA_WIDTH) +: DATA_WIDTH]   = b_q[k][elem_lsb(int'(idx_i) - k, DATA_WIDTH) +: DATA_WIDTH];
         end
      end
   end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A/B operands and drives skewed edges into a PE array until results are acked
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int BUS_WIDTH  = 64,
   localparam int MD         = max_dim(BUS_WIDTH, DATA_WIDTH),
   localparam int AW         = addr_w(MD),
   localparam int CW         = cnt_w(MD),
   localparam int FC         = feed_cycles(MD)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wr_en_i,
   input  logic                     wr_sel_i,
   input  logic [AW-1:0]            wr_addr_i,
   input  logic [BUS_WIDTH-1:0]     wr_data_i,
   output logic                     wr_ready_o,
   input  logic                     start_i,
   input  logic                     mode_i,
   input  logic                     res_ack_i,
   output logic [MD*DATA_WIDTH-1:0] left_o,
   output logic [MD*DATA_WIDTH-1:0] up_o,
   output logic                     start_bit_o,
   output logic                     mode_bit_o,
   output logic                     busy_o,
   output logic                     done_o
);
   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           rd_idx;
   logic [MD*DATA_WIDTH-1:0] left_n, up_n;

   assign wr_ready_o = (state == IDLE) && !start_i;
   assign busy_o     = state != IDLE;
   // outputs are registered, so read one step ahead of the counter
   assign rd_idx     = (state == IDLE) ? '0 : cnt + 1'b1;

   feeder_operand_bank #(.DATA_WIDTH(DATA_WIDTH), .BUS_WIDTH(BUS_WIDTH)) u_bank (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we_i   (wr_en_i && wr_ready_o),
      .sel_i  (wr_sel_i),
      .addr_i (wr_addr_i),
      .data_i (wr_data_i),
      .idx_i  (rd_idx),
      .left_o (left_n),
      .up_o   (up_n)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         cnt         <= '0;
         left_o      <= '0;
         up_o        <= '0;
         start_bit_o <= 1'b0;
         mode_bit_o  <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               state       <= FEED;
               cnt         <= '0;
               start_bit_o <= 1'b1;
               mode_bit_o  <= mode_i;
               left_o      <= left_n;
               up_o        <= up_n;
            end
            FEED: if (cnt == CW'(FC - 1)) begin
               state  <= HOLD;
               done_o <= 1'b1;
               left_o <= '0;
               up_o   <= '0;
            end else begin
               cnt    <= cnt + 1'b1;
               left_o <= left_n;
               up_o   <= up_n;
            end
            HOLD: begin
               done_o <= 1'b0;
               if (res_ack_i) begin
                  state       <= IDLE;
                  start_bit_o <= 1'b0;
                  mode_bit_o  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: table-driven feeds with a per-cycle expected-operand queue and an array model
module tb_systolic_feeder;
   logic        clk_i = 0, rst_ni = 1;
   logic        wr_en_i = 0, wr_sel_i = 0, start_i = 0, mode_i = 0, res_ack_i = 0;
   logic [0:0]  wr_addr_i = '0;
   logic [63:0] wr_data_i = '0;
   logic        wr_ready_o, start_bit_o, mode_bit_o, busy_o, done_o;
   logic [63:0] left_o, up_o;

   always #5 clk_i = ~clk_i;

   systolic_feeder #(.DATA_WIDTH(32), .BUS_WIDTH(64)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
      .start_i(start_i), .mode_i(mode_i), .res_ack_i(res_ack_i),
      .left_o(left_o), .up_o(up_o), .start_bit_o(start_bit_o),
      .mode_bit_o(mode_bit_o), .busy_o(busy_o), .done_o(done_o)
   );

   typedef struct { int a[2][2]; int b[2][2]; bit mode; int c[2][2]; } vec_t;
   typedef struct { logic [63:0] l; logic [63:0] u; } exp_t;

   exp_t        q[$];
   int          ma[2][2], mb[2][2], cg[2][2];
   int          n_chk = 0, n_pass = 0;
   logic [63:0] lrec[4], urec[4];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [63:0] pack2(input int e0, input int e1);
      return {e1[31:0], e0[31:0]};
   endfunction

   function automatic exp_t model(input int t);
      exp_t e;
      e.l = '0;
      e.u = '0;
      for (int k = 0; k < 2; k++)
         if (t - k >= 0 && t - k < 2) begin
            e.l[k*32 +: 32] = ma[k][t-k];
            e.u[k*32 +: 32] = mb[t-k][k];
         end
      return e;
   endfunction

   task automatic write_all(input int a[2][2], input int b[2][2]);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         wr_en_i   = 1;
         wr_sel_i  = i[1];
         wr_addr_i = i[0];
         if (i < 2) wr_data_i = pack2(a[i][0], a[i][1]);
         else       wr_data_i = pack2(b[0][i-2], b[1][i-2]);
         if (i == 0) chk("wr_ready idle", {63'd0, wr_ready_o}, 64'd1);
      end
      @(negedge clk_i);
      wr_en_i = 0;
      ma = a;
      mb = b;
   endtask

   // restart also pokes start_i and res_ack_i during FEED, both of which must be ignored
   task automatic feed(input bit mode, input bit now, input bit collide, input bit restart);
      exp_t e;
      int   s;
      for (int t = 0; t < 4; t++) q.push_back(model(t));
      if (!now) @(negedge clk_i);
      start_i = 1;
      mode_i  = mode;
      if (collide) begin
         wr_en_i = 1; wr_sel_i = 0; wr_addr_i = 0; wr_data_i = pack2(99, 99);
         #1 chk("wr_ready with start", {63'd0, wr_ready_o}, 64'd0);
      end
      for (int t = 0; t < 4; t++) begin
         @(negedge clk_i);
         start_i   = restart && t == 0;
         res_ack_i = restart && t == 0;
         wr_en_i   = 0;
         mode_i    = !mode;
         e = q.pop_front();
         chk($sformatf("left t%0d", t), left_o, e.l);
         chk($sformatf("up t%0d", t), up_o, e.u);
         chk($sformatf("start_bit t%0d", t), {63'd0, start_bit_o}, 64'd1);
         chk($sformatf("mode_bit t%0d", t), {63'd0, mode_bit_o}, {63'd0, mode});
         chk($sformatf("done t%0d", t), {63'd0, done_o}, 64'd0);
         lrec[t] = left_o;
         urec[t] = up_o;
      end
      @(negedge clk_i);
      start_i = 0;
      mode_i  = 0;
      chk("done t4", {63'd0, done_o}, 64'd1);
      chk("busy t4", {63'd0, busy_o}, 64'd1);
      chk("mode_bit t4", {63'd0, mode_bit_o}, {63'd0, mode});
      // PE(r,c) sees left slot r delayed c cycles and up slot c delayed r cycles
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            s = mode ? 100 : 0;
            for (int t = 0; t < 6; t++)
               if (t - c >= 0 && t - c < 4 && t - r >= 0 && t - r < 4)
                  s += signed'(lrec[t-c][r*32 +: 32]) * signed'(urec[t-r][c*32 +: 32]);
            cg[r][c] = s;
         end
   endtask

   task automatic hold_ack(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         chk("hold start_bit", {63'd0, start_bit_o}, 64'd1);
         chk("hold left", left_o, 64'd0);
         chk("hold up", up_o, 64'd0);
         chk("hold done", {63'd0, done_o}, 64'd0);
      end
      res_ack_i = 1;
      @(negedge clk_i);
      res_ack_i = 0;
      chk("ack start_bit", {63'd0, start_bit_o}, 64'd0);
      chk("ack busy", {63'd0, busy_o}, 64'd0);
      chk("ack mode_bit", {63'd0, mode_bit_o}, 64'd0);
   endtask

   task automatic chk_c(input string nm, input int c[2][2]);
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 2; k++)
            chk($sformatf("%s C[%0d][%0d]", nm, r, k), 64'(cg[r][k]), 64'(c[r][k]));
   endtask

   initial begin
      vec_t tbl[2];
      int   z[2][2];
      int   plain[2][2];
      z = '{default: 0};
      tbl[0].a = '{'{1, 2}, '{3, 4}};
      tbl[0].b = '{'{5, 6}, '{7, 8}};
      tbl[0].mode = 0;
      tbl[0].c = '{'{19, 22}, '{43, 50}};
      tbl[1].a = '{'{-1, 0}, '{0, -1}};
      tbl[1].b = '{'{-7, 3}, '{2, -5}};
      tbl[1].mode = 1;
      tbl[1].c = '{'{107, 97}, '{98, 105}};
      plain = '{'{7, -3}, '{-2, 5}};

      #2 rst_ni = 0;
      #1;
      chk("rst start_bit", {63'd0, start_bit_o}, 64'd0);
      chk("rst left", left_o, 64'd0);
      chk("rst up", up_o, 64'd0);
      chk("rst busy", {63'd0, busy_o}, 64'd0);
      chk("rst done", {63'd0, done_o}, 64'd0);
      chk("rst mode_bit", {63'd0, mode_bit_o}, 64'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1;

      foreach (tbl[i]) begin
         write_all(tbl[i].a, tbl[i].b);
         feed(tbl[i].mode, 0, 0, 0);
         chk_c($sformatf("vec%0d", i), tbl[i].c);
         hold_ack(10);
      end

      feed(0, 0, 1, 1);
      chk_c("collide", plain);
      hold_ack(2);

      write_all(tbl[0].a, tbl[0].b);
      @(negedge clk_i);
      start_i = 1;
      @(negedge clk_i);
      start_i = 0;
      @(posedge clk_i);
      #2 rst_ni = 0;
      #1;
      chk("async start_bit", {63'd0, start_bit_o}, 64'd0);
      chk("async left", left_o, 64'd0);
      chk("async up", up_o, 64'd0);
      chk("async busy", {63'd0, busy_o}, 64'd0);
      @(negedge clk_i);
      rst_ni = 1;
      ma = z;
      mb = z;
      feed(0, 0, 0, 0);
      chk_c("after reset", z);
      hold_ack(1);

      write_all(tbl[0].a, tbl[0].b);
      feed(0, 0, 0, 0);
      chk_c("b2b first", tbl[0].c);
      hold_ack(1);
      feed(0, 1, 0, 0);
      chk_c("b2b second", tbl[0].c);
      hold_ack(1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
